// File: rtl/crc_serial_core.sv
// crc_serial_core: bit-serial CRC engine in the fast clock domain.
// Accepts a one-cycle start pulse, shifts DATA_W bits through the CRC
// register (one per f_clk) and reports the result with a done pulse.
// Optional macro CRC_REFLECT_EN: byte-wise LSB-first input (refin) and a
// bit-reversed result before XOROUT (refout). DATA_W must then be a
// multiple of 8.
module crc_serial_core #(
    parameter int unsigned          DATA_W = 32,
    parameter int unsigned          CRC_W  = 16,
    parameter logic [CRC_W-1:0]     POLY   = 16'h1021,
    parameter logic [CRC_W-1:0]     INIT   = 16'hFFFF,
    parameter logic [CRC_W-1:0]     XOROUT = 16'h0000
) (
    input  logic              f_clk,
    input  logic              frst_n,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_drop,
    output logic [CRC_W-1:0]  o_crc
);

    localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] shreg;
    logic [CRC_W-1:0]  crc_work;
    logic [CRC_W-1:0]  crc_step;
    logic [CNT_W-1:0]  cnt;
    logic              fb;
    logic              last_bit;
    logic              accept;

    // Reorders the captured word so the datapath always consumes shreg MSB-first.
    // With reflection, each byte is bit-reversed in place, so bytes still go
    // most significant first while bits within a byte go LSB-first.
    function automatic logic [DATA_W-1:0] order_in(input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
`ifdef CRC_REFLECT_EN
        r = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            r[(i / 8) * 8 + 7 - (i % 8)] = d[i];
        end
`else
        r = d;
`endif
        return r;
    endfunction

    // Output reflection across the full CRC width when enabled.
    function automatic logic [CRC_W-1:0] order_out(input logic [CRC_W-1:0] c);
        logic [CRC_W-1:0] r;
`ifdef CRC_REFLECT_EN
        r = '0;
        for (int unsigned i = 0; i < CRC_W; i++) begin
            r[CRC_W-1-i] = c[i];
        end
`else
        r = c;
`endif
        return r;
    endfunction

    // One CRC step for the current data bit, plus control decodes.
    always_comb begin
        fb       = crc_work[CRC_W-1] ^ shreg[DATA_W-1];
        crc_step = (crc_work << 1) ^ (fb ? POLY : '0);
        last_bit = (cnt == CNT_W'(DATA_W - 1));
        accept   = i_start && (state != SHIFT);
        o_busy   = (state == SHIFT);
    end

    // Next-state logic; a start in DONE behaves as in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_start) state_nxt = SHIFT;
            SHIFT:   if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = i_start ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge f_clk or negedge frst_n) begin
        if (!frst_n) state <= IDLE;
        else         state <= state_nxt;
    end

    // Working registers: load on an accepted start, shift while in SHIFT.
    always_ff @(posedge f_clk or negedge frst_n) begin
        if (!frst_n) begin
            shreg    <= '0;
            crc_work <= '0;
            cnt      <= '0;
        end else if (accept) begin
            shreg    <= order_in(i_data);
            crc_work <= INIT;
            cnt      <= '0;
        end else if (state == SHIFT) begin
            shreg    <= shreg << 1;
            crc_work <= crc_step;
            cnt      <= cnt + 1'b1;
        end
    end

    // Registered outputs: done follows the DONE state by one cycle, drop flags
    // an ignored start, and the result updates only on the edge entering DONE.
    always_ff @(posedge f_clk or negedge frst_n) begin
        if (!frst_n) begin
            o_done <= 1'b0;
            o_drop <= 1'b0;
            o_crc  <= '0;
        end else begin
            o_done <= (state == DONE);
            o_drop <= i_start && (state == SHIFT);
            if (state == SHIFT && last_bit) begin
                o_crc <= order_out(crc_step) ^ XOROUT;
            end
        end
    end

endmodule
